// File: rtl/mul8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller built on an external 4x2 multiplier.
// Eight partial products are issued one per cycle and shift-accumulated into a 16-bit result.
module mul8x8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [3:0]  mul_x,
    output logic [1:0]  mul_y,
    input  logic [5:0]  mul_m
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  k_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [15:0] pp;
    logic [3:0]  shamt;
    logic        start_ready_q;
    logic        res_valid_q;
    logic        busy_q;

    // Step k selects nibble k[0] of a and 2-bit digit k[2:1] of b.
    always_comb begin
        mul_x = 4'd0;
        mul_y = 2'd0;
        if (state_q == RUN) begin
            mul_x = k_q[0] ? a_q[7:4] : a_q[3:0];
            unique case (k_q[2:1])
                2'd0: mul_y = b_q[1:0];
                2'd1: mul_y = b_q[3:2];
                2'd2: mul_y = b_q[5:4];
                2'd3: mul_y = b_q[7:6];
            endcase
        end
    end

    assign shamt = {1'b0, k_q[0], 2'b00} + {1'b0, k_q[2:1], 1'b0};
    assign pp    = {10'd0, mul_m} << shamt;
    assign acc_d = acc_q + pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= 3'd0;
            a_q           <= 8'd0;
            b_q           <= 8'd0;
            acc_q         <= 16'd0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q           <= a;
                        b_q           <= b;
                        acc_q         <= 16'd0;
                        k_q           <= 3'd0;
                        state_q       <= RUN;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q       <= IDLE;
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    res_valid_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign product     = acc_q;

endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// Directed bench for mul8x8_seq_ctrl with a behavioural 4x2 multiplier on the mul_* ports.
// Table-driven products plus hand-written backpressure and reset-abort sequences.
module tb_mul8x8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] product;
    logic        busy;
    logic [3:0]  mul_x;
    logic [1:0]  mul_y;
    logic [5:0]  mul_m;

    int checks = 0;
    int errors = 0;

    logic [3:0] sx [8];
    logic [1:0] sy [8];
    logic [3:0] ex_x [8] = '{4'hD, 4'h0, 4'hD, 4'h0, 4'hD, 4'h0, 4'hD, 4'h0};
    logic [1:0] ex_y [8] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    longint t_acc;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    mul8x8_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_m       (mul_m)
    );

    assign mul_m = {2'b00, mul_x} * {4'b0000, mul_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired", name);
    endtask

    // Called at a negedge; returns at the negedge where res_valid is first seen.
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic rr,
                         output logic [15:0] p, output int lat);
        int n;
        n = 0;
        a = ai;
        b = bi;
        start_valid = 1'b1;
        res_ready = rr;
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            fail_now("accept_timeout");
            start_valid = 1'b0;
            p = 16'hxxxx;
            lat = -1;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        #1 start_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) break;
            if (i < 8) begin
                sx[i] = mul_x;
                sy[i] = mul_y;
            end
            @(posedge clk);
            lat++;
        end
        if (!res_valid) fail_now("result_timeout");
        p = product;
    endtask

    initial begin
        logic [15:0] p;
        int          lat;
        longint      prev_t;
        logic        seen;

        vecs[0] = '{8'h0D, 8'h03, 16'h0027};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'hAB, 8'h00, 16'h0000};
        vecs[3] = '{8'h00, 8'hCD, 16'h0000};
        vecs[4] = '{8'h80, 8'h02, 16'h0100};
        vecs[5] = '{8'h12, 8'h34, 16'h03A8};
        vecs[6] = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[7] = '{8'hF0, 8'h0F, 16'h0E10};

        rst_n = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_product", product, 16'h0000);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_mul_x", mul_x, 4'h0);
        chk("rst_mul_y", mul_y, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        prev_t = 0;
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b1, p, lat);
            chk($sformatf("prod_%0d", i), p, vecs[i].p);
            chk($sformatf("lat_%0d", i), lat, 8);
            chk($sformatf("busy_done_%0d", i), busy, 1'b1);
            if (i > 0) chk($sformatf("spacing_%0d", i), t_acc - prev_t, 100);
            prev_t = t_acc;
            if (i == 0) begin
                for (int j = 0; j < 8; j++) begin
                    chk($sformatf("mulx_%0d", j), sx[j], ex_x[j]);
                    chk($sformatf("muly_%0d", j), sy[j], ex_y[j]);
                end
            end
        end

        // Backpressure with a competing request held during RUN and DONE.
        @(negedge clk);
        @(negedge clk);
        a = 8'hD0;
        b = 8'h0E;
        start_valid = 1'b1;
        res_ready = 1'b0;
        @(posedge clk);
        #1 a = 8'h11;
        b = 8'h11;
        @(negedge clk);
        chk("bp_ready_run", start_ready, 1'b0);
        chk("bp_valid_run", res_valid, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_valid", res_valid, 1'b1);
        chk("bp_product", product, 16'h0B60);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_p_%0d", i), product, 16'h0B60);
            chk($sformatf("bp_hold_v_%0d", i), res_valid, 1'b1);
            chk($sformatf("bp_hold_b_%0d", i), busy, 1'b1);
            chk($sformatf("bp_hold_r_%0d", i), start_ready, 1'b0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", start_ready, 1'b1);
        chk("bp_release_valid", res_valid, 1'b0);
        chk("bp_idle_product", product, 16'h0B60);

        // Asynchronous reset in the middle of a stalled DONE.
        do_op(8'h0D, 8'h03, 1'b0, p, lat);
        chk("rd_product", p, 16'h0027);
        #3 rst_n = 1'b0;
        #1;
        chk("rd_product0", product, 16'h0000);
        chk("rd_valid0", res_valid, 1'b0);
        chk("rd_busy0", busy, 1'b0);
        chk("rd_ready1", start_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset at step 4 of 0xFF*0xFF.
        a = 8'hFF;
        b = 8'hFF;
        start_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rr_step4_x", mul_x, 4'hF);
        chk("rr_step4_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_mul_x", mul_x, 4'h0);
        chk("rr_mul_y", mul_y, 2'd0);
        chk("rr_busy", busy, 1'b0);
        chk("rr_product", product, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | res_valid;
        end
        chk("rr_no_valid", seen, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, p, lat);
        chk("rr_next_product", p, 16'h03A8);
        chk("rr_next_lat", lat, 8);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul8x8_seq_ctrl.md
# mul8x8_seq_ctrl

Sequential controller that computes an unsigned 8x8 -> 16-bit product by time-multiplexing the team's existing combinational 4x2 multiplier (4-bit x, 2-bit y, 6-bit m). It latches the operands on a valid/ready handshake and issues eight 4x2 partial-product requests to the external multiplier instance, one per cycle. It shift-accumulates the returned partial products and presents the result on a valid/ready output. The multiplier instance sits outside this block and is wired to the mul_* ports.

## Interface
Parameters: none (widths fixed by the 4x2 datapath).

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start_valid  input  1  operand request valid
- start_ready  output  1  block can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- res_valid  output  1  product valid
- res_ready  input  1  consumer accepts product
- product  output  16  a*b, unsigned
- busy  output  1  high whenever state != IDLE
- mul_x  output  4  to 4x2 multiplier x
- mul_y  output  2  to 4x2 multiplier y
- mul_m  input  6  from 4x2 multiplier m (combinational, same cycle)

## Operation
- States: IDLE, RUN, DONE. Step counter k, 3 bits.
- start_ready = (state==IDLE); res_valid = (state==DONE); busy = (state!=IDLE).
- IDLE: on start_valid & start_ready, latch a_r<=a and b_r<=b; acc<=0; k<=0; go to RUN.
- RUN, step k: nibble n=k[0], digit d=k[2:1].
  - mul_x = n ? a_r[7:4] : a_r[3:0].
  - mul_y = b_r[2d+1:2d].
  - acc <= acc + (zero-extend(mul_m) << (4n + 2d)).
  - k<=k+1. At k==7, go to DONE after this accumulate.
- DONE: product holds acc. On res_ready, go to IDLE.
- mul_x/mul_y = 0 in IDLE and DONE.
- Width rule: acc is 16 bits. The maximum partial product is 45, and the maximum total is 65025, so no overflow or truncation is possible.
- start_valid is ignored outside IDLE. Changes on a/b after acceptance have no effect.
- There is no same-cycle turnaround: DONE->IDLE consumes one edge, and the next accept happens no earlier than the following edge.
- product register updates only while in RUN/DONE. It holds its last value in IDLE.

## Timing
- Reset (async assert, any state) forces:
  - state=IDLE, k=0, acc=0, product=0
  - res_valid=0, busy=0, start_ready=1
  - mul_x=0, mul_y=0
- Reset mid-RUN or mid-DONE aborts the operation. No res_valid is produced for the aborted operation.
- Latency:
  - Accept edge E0.
  - Accumulate edges E1..E8, with E8 the step-7 accumulate and DONE entry.
  - res_valid is high in the cycle after E8: 8 cycles after accept.
- Backpressure: while res_valid=1 and res_ready=0, product, res_valid and busy are held stable, and start_ready=0.
- Minimum issue interval is 10 cycles: accept, 8 RUN cycles, 1 DONE cycle with res_ready=1.
- mul_m is sampled on the same edge that mul_x/mul_y are driven for. The block inserts no extra pipeline stage.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle.
  - Required: all outputs take reset values immediately (product=0, res_valid=0, busy=0, start_ready=1).
- Basic product:
  - Stimulus: a=0x0D, b=0x03, res_ready=1.
  - Required: product=0x0027 with res_valid exactly 8 cycles after accept.
  - Required mul_x/mul_y sequence: (D,3),(0,3),(D,0),(0,0),(D,0),(0,0),(D,0),(0,0).
- Extremes:
  - 0xFF*0xFF must give 0xFE01.
  - 0xAB*0x00 must give 0x0000.
  - 0x00*0xCD must give 0x0000.
  - 0x80*0x02 must give 0x0100.
- Backpressure and ignored request:
  - Stimulus: a=0xD0, b=0x0E; hold res_ready=0 for 5 cycles after res_valid; pulse start_valid with a=0x11 during RUN and DONE.
  - Required: product=0x0B60 held stable for the full backpressure window.
  - Required: start_ready=0 and the pulsed request is ignored.
  - Required: after res_ready=1, start_ready=1 one cycle later.
- Reset mid-operation:
  - Stimulus: assert rst_n low at step 4 of 0xFF*0xFF, then release.
  - Required: res_valid never rises for the aborted operation.
  - Required: a subsequent 0x12*0x34 gives 0x03A8 with standard 8-cycle latency.
- Back-to-back:
  - Stimulus: 0x0F*0x0F followed immediately by 0xF0*0x0F, res_ready tied 1.
  - Required: results 0x00E1 and 0x0E10, with accepts spaced exactly 10 cycles apart.
